increment_handshake: RTL and testbench

- Elastic, handshake-style increment stage: each accepted signed word leaves as word + INCREMENT.
- Zero-latency combinational pass-through when downstream is ready; a one-entry skid register holds the result when downstream stalls.
- Port list matches the positional arg/ret convention of lowered handshake functions, so the stage drops in wherever a function `main` with that signature is expected.

---
 rtl/increment_handshake_pkg.sv | 15 +
 rtl/increment_handshake_skid_buffer.sv | 83 ++++++++
 rtl/increment_handshake.sv | 39 +++
 tb/tb_increment_handshake.sv | 133 +++++++++++++
 4 files changed

// File: rtl/increment_handshake_pkg.sv
// Shared types and defaults for the increment handshake stage.
// The skid register is a two-state machine: empty (bypass) or holding one word.
package increment_handshake_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int DEF_INCREMENT = 1;

    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_e;

endpackage : increment_handshake_pkg

// File: rtl/increment_handshake_skid_buffer.sv
// Generic one-entry skid register with zero-latency bypass.
// Holds a word only when upstream offers it while downstream is stalled.
//
// state      | meaning
// SKID_EMPTY | bypass: out follows in, upstream ready
// SKID_FULL  | one word held in data_q, upstream back-pressured until drained
module skid_buffer
    import increment_handshake_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             capture_c;

    assign capture_c = (state_q == SKID_EMPTY) && in_valid_i && !out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SKID_EMPTY: begin
                if (capture_c) begin
                    state_d = SKID_FULL;
                    data_d  = in_data_i;
                end
            end
            SKID_FULL: begin
                if (out_ready_i) begin
                    state_d = SKID_EMPTY;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Outputs are forced quiet while reset is asserted, not just after the edge.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        if (rst_ni) begin
            case (state_q)
                SKID_EMPTY: begin
                    in_ready_o  = 1'b1;
                    out_valid_o = in_valid_i;
                    out_data_o  = in_data_i;
                end
                SKID_FULL: begin
                    in_ready_o  = 1'b0;
                    out_valid_o = 1'b1;
                    out_data_o  = data_q;
                end
                default: begin
                    in_ready_o  = 1'b0;
                    out_valid_o = 1'b0;
                    out_data_o  = '0;
                end
            endcase
        end
    end

endmodule : skid_buffer

// File: rtl/increment_handshake.sv
// Elastic increment stage: every accepted word leaves as word + INCREMENT.
// Port names follow the positional arg/ret convention of lowered handshake functions.
module increment_handshake
    import increment_handshake_pkg::*;
#(
    parameter int        WIDTH     = DATA_WIDTH,
    parameter int signed INCREMENT = DEF_INCREMENT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] arg0,
    input  logic             arg1,
    input  logic             arg2,
    output logic             ret0,
    output logic [WIDTH-1:0] ret1,
    output logic             ret2
);

    logic [WIDTH-1:0] inc_c;
    logic [WIDTH-1:0] sum_c;

    // Modulo-2^WIDTH add; the adder sits before the skid so a held word is already incremented.
    assign inc_c = WIDTH'(INCREMENT);
    assign sum_c = arg0 + inc_c;

    skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .in_data_i   (sum_c),
        .in_valid_i  (arg1),
        .in_ready_o  (ret0),
        .out_data_o  (ret1),
        .out_valid_o (ret2),
        .out_ready_i (arg2)
    );

endmodule : increment_handshake

// File: tb/tb_increment_handshake.sv
// Self-checking bench for increment_handshake using an expected-data queue.
module tb_increment_handshake;
    import increment_handshake_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [31:0] arg0;
    logic        arg1;
    logic        arg2;
    logic        ret0;
    logic [31:0] ret1;
    logic        ret2;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb[$];
    logic        m_full = 1'b0;

    increment_handshake #(
        .WIDTH     (32),
        .INCREMENT (1)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .arg0    (arg0),
        .arg1    (arg1),
        .arg2    (arg2),
        .ret0    (ret0),
        .ret1    (ret1),
        .ret2    (ret2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: drive, check combinational outputs against the model, then clock.
    task automatic cyc(input logic [31:0] a0, input logic v, input logic r);
        logic exp_valid;
        arg0 = a0;
        arg1 = v;
        arg2 = r;
        #1;
        exp_valid = m_full || v;
        chk("ret0", {31'd0, ret0}, {31'd0, !m_full});
        chk("ret2", {31'd0, ret2}, {31'd0, exp_valid});
        if (v && !m_full) sb.push_back(a0 + 32'd1);
        if (exp_valid) begin
            if (sb.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
            else begin
                chk("ret1", ret1, sb[0]);
                if (r) void'(sb.pop_front());
            end
        end
        if (!m_full && v && !r) m_full = 1'b1;
        else if (m_full && r) m_full = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        data_t s;
        reset_n = 1'b0;
        arg0    = 32'd420;
        arg1    = 1'b1;
        arg2    = 1'b1;
        #3;
        chk("rst_ret0", {31'd0, ret0}, 32'd0);
        chk("rst_ret2", {31'd0, ret2}, 32'd0);
        chk("rst_ret1", ret1, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("pt_420", ret1, 32'd421);

        cyc(32'd420, 1'b1, 1'b1);
        s = -69;
        cyc(s, 1'b1, 1'b1);
        #0 chk("pt_neg", 32'($signed(s) + 1), 32'hFFFF_FFBC);
        cyc(32'h7FFF_FFFF, 1'b1, 1'b1);
        cyc(32'hFFFF_FFFF, 1'b1, 1'b1);

        // stall: 5 held as 6 while arg0 moves to 9, then drain, then pass-through 10
        cyc(32'd5, 1'b1, 1'b0);
        cyc(32'd9, 1'b1, 1'b0);
        cyc(32'd9, 1'b1, 1'b1);
        cyc(32'd9, 1'b1, 1'b1);

        // held word drains with arg1 low
        cyc(32'd100, 1'b1, 1'b0);
        cyc(32'd0, 1'b0, 1'b0);
        cyc(32'd0, 1'b0, 1'b1);

        // reset mid-stall discards the held word
        cyc(32'd77, 1'b1, 1'b0);
        arg1    = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_ret2", {31'd0, ret2}, 32'd0);
        chk("mid_rst_ret0", {31'd0, ret0}, 32'd0);
        sb.delete();
        m_full = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc(32'd0, 1'b0, 1'b0);

        // idle with ready toggling
        for (int i = 0; i < 10; i++) cyc(32'd1234, 1'b0, 1'(i % 2));

        for (int i = 0; i < 300; i++)
            cyc($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        cyc(32'd0, 1'b0, 1'b1);
        cyc(32'd0, 1'b0, 1'b1);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_increment_handshake
